issue_buffer: RTL
=================

# issue_buffer

Parametrised in-order instruction buffer and group-issue selector between the fetch/decode boundary and the EX stage. It is the N-wide successor of the fixed dual-issue decode pairing. It accepts up to FETCH_W pre-decoded instructions per cycle into a circular buffer of DEPTH entries. Each cycle it issues the longest legal in-order group, up to ISSUE_W instructions, from the head, ending the group at register hazards and branches.

## Interface
- FETCH_W, 2, instructions offered per cycle (1..4)
- ISSUE_W, 2, maximum instructions issued per cycle (1..4)
- DEPTH, 8, buffer entries; power of two, DEPTH >= FETCH_W + ISSUE_W
- PAYLOAD_W, 64, opaque payload per instruction ({pc, instruction})
- CNT_W, 32, width of the performance counters
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all buffered entries and same-cycle input
- in_valid  in  FETCH_W  per-lane valid; must be contiguous from lane 0
- in_payload  in  FETCH_W*PAYLOAD_W  lane k at bits [k*PAYLOAD_W +: PAYLOAD_W]
- in_dst, in_src_a, in_src_b  in  FETCH_W*5 each  register numbers; 0 = none
- in_wr  in  FETCH_W  lane writes in_dst
- in_is_branch  in  FETCH_W  lane is a branch/jump
- in_ready  out  1  buffer can take a full FETCH_W bundle this cycle
- out_valid  out  ISSUE_W  issue-slot valid; always contiguous from slot 0
- out_payload  out  ISSUE_W*PAYLOAD_W  slot payloads, head entry in slot 0
- issue_stall  in  1  downstream stall; no entry leaves while high
- count  out  $clog2(DEPTH)+1  occupied entries
- multi_issue_cnt  out  CNT_W  cycles in which more than one instruction issued
- hazard_split_cnt  out  CNT_W  cycles in which a group was cut by a RAW or WAW hazard

## Operation
- Storage: entry arrays, head pointer, tail pointer and count register; pointers wrap modulo DEPTH.
- in_ready = (DEPTH - count >= FETCH_W), computed from registered count. It ignores same-cycle dequeue.
- Enqueue: when in_ready && !flush, the popcount(in_valid) lanes are written in lane order at tail. in_valid while !in_ready is dropped; the source must hold it.
- Issue group: slot k (k < ISSUE_W) is valid iff all of the following hold:
  - slot k-1 is valid (slot 0 needs count > 0);
  - entry head+k exists (k < count);
  - no earlier slot j < k in the group is a branch;
  - no RAW: src_a/src_b of k (nonzero) does not equal dst of any earlier slot with wr=1;
  - no WAW: wr && dst of k (nonzero) does not equal dst of any earlier slot with wr=1.
- A branch may issue in any slot but ends the group; its delay slot issues next cycle.
- out_valid and out_payload are combinational from registered state (show-ahead). They are independent of issue_stall.
- Dequeue: when !issue_stall && !flush, popcount(out_valid) entries are removed and head advances by that amount.
- Dequeue and enqueue in the same cycle: count_next = count + enq - deq.
- flush: head = tail = count = 0 next cycle. Flush wins over same-cycle enqueue and dequeue. Counters are not cleared.
- Counters: increment only on cycles with an actual dequeue (!issue_stall && !flush).
  - multi_issue_cnt increments when deq > 1.
  - hazard_split_cnt increments when slot k was blocked only by RAW/WAW, with entry present and no earlier branch.
  - Both wrap modulo 2^CNT_W.
- rst: head, tail, count and both counters = 0; out_valid = 0; in_ready = 1. Reset mid-operation discards all contents.

## Timing
- Enqueue-to-visible latency: 1 cycle. An entry written at edge N appears on out_* after edge N.
- An issued entry leaves at the edge ending its issue cycle.
- Full: count = DEPTH. in_ready stays low until DEPTH - count >= FETCH_W.
- Empty: out_valid = 0. There is no bypass from in_* to out_*.
- Wrap-around: a group spanning index DEPTH-1 to 0 issues identically to a non-wrapping group.

## Test plan
- After reset, enqueue {add r1; add r2}, both independent, FETCH_W=ISSUE_W=2 -> next cycle out_valid=2'b11; multi_issue_cnt=1 after the issue edge.
- Enqueue {add r3,r1,r2; sub r4,r3,r5} -> out_valid=2'b01, then 2'b01 on the following cycle; hazard_split_cnt=1.
- Enqueue {beq; nop} -> slot 0 issues the branch alone, nop issues next cycle; WAW pair {lw r6; addi r6} behaves the same.
- Hold issue_stall=1 and offer bundles every cycle with DEPTH=8 -> count reaches 8, in_ready=0, out_* stable. Release the stall -> entries drain in order, in_ready returns once count <= 6.
- Run 20 bundles through with ISSUE_W=1 so the pointers wrap -> output order equals input order, with no loss or duplication.
- flush with count=5 plus a same-cycle bundle -> next cycle count=0, out_valid=0, counters retained; rst mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/issue_buffer.sv
// rtl/issue_buffer.sv - in-order circular instruction buffer with hazard-aware group issue
// Accepts up to FETCH_W instructions per cycle and issues the longest legal in-order group of up to ISSUE_W.
module issue_buffer #(
    parameter int FETCH_W   = 2,
    parameter int ISSUE_W   = 2,
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [FETCH_W-1:0]             in_valid,
    input  logic [FETCH_W*PAYLOAD_W-1:0]   in_payload,
    input  logic [FETCH_W*5-1:0]           in_dst,
    input  logic [FETCH_W*5-1:0]           in_src_a,
    input  logic [FETCH_W*5-1:0]           in_src_b,
    input  logic [FETCH_W-1:0]             in_wr,
    input  logic [FETCH_W-1:0]             in_is_branch,
    output logic                           in_ready,
    output logic [ISSUE_W-1:0]             out_valid,
    output logic [ISSUE_W*PAYLOAD_W-1:0]   out_payload,
    input  logic                           issue_stall,
    output logic [$clog2(DEPTH):0]         count,
    output logic [CNT_W-1:0]               multi_issue_cnt,
    output logic [CNT_W-1:0]               hazard_split_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [4:0]           r_dst     [DEPTH];
    logic [4:0]           r_src_a   [DEPTH];
    logic [4:0]           r_src_b   [DEPTH];
    logic [DEPTH-1:0]     r_wr;
    logic [DEPTH-1:0]     r_br;

    logic [AW-1:0]        r_head;
    logic [AW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    logic [CNT_W-1:0]     r_multi_cnt;
    logic [CNT_W-1:0]     r_hazard_cnt;

    logic                 w_enq_ok;
    logic                 w_do_deq;
    logic [CW-1:0]        w_enq_n;
    logic [CW-1:0]        w_deq_n;
    logic [AW-1:0]        w_idx [ISSUE_W];
    logic [ISSUE_W-1:0]   w_out_valid;
    logic                 w_hazard_cut;
    logic                 w_chain;
    logic                 w_br_seen;
    logic                 w_present;
    logic                 w_raw;
    logic                 w_waw;

    // Readiness looks only at registered occupancy, never at this cycle's dequeue.
    assign in_ready = ((CW'(DEPTH) - r_count) >= CW'(FETCH_W));
    assign w_enq_ok = in_ready && !flush;
    assign w_do_deq = !issue_stall && !flush;
    assign count            = r_count;
    assign multi_issue_cnt  = r_multi_cnt;
    assign hazard_split_cnt = r_hazard_cnt;
    assign out_valid        = w_out_valid;

    always_comb begin
        w_enq_n = '0;
        if (w_enq_ok) begin
            for (int k = 0; k < FETCH_W; k++) begin
                w_enq_n = w_enq_n + CW'(in_valid[k]);
            end
        end
    end

    // Group selection walks slots from the head; the first illegal slot ends the group.
    always_comb begin
        w_out_valid  = '0;
        w_hazard_cut = 1'b0;
        w_chain      = 1'b1;
        w_br_seen    = 1'b0;
        w_present    = 1'b0;
        w_raw        = 1'b0;
        w_waw        = 1'b0;
        out_payload  = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            w_idx[k]  = r_head + AW'(k);
            w_present = (CW'(k) < r_count);
            w_raw     = 1'b0;
            w_waw     = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (r_wr[w_idx[j]]) begin
                    if (r_src_a[w_idx[k]] != 5'd0 && r_src_a[w_idx[k]] == r_dst[w_idx[j]])
                        w_raw = 1'b1;
                    if (r_src_b[w_idx[k]] != 5'd0 && r_src_b[w_idx[k]] == r_dst[w_idx[j]])
                        w_raw = 1'b1;
                    if (r_wr[w_idx[k]] && r_dst[w_idx[k]] != 5'd0 &&
                        r_dst[w_idx[k]] == r_dst[w_idx[j]])
                        w_waw = 1'b1;
                end
            end
            out_payload[k*PAYLOAD_W +: PAYLOAD_W] = r_payload[w_idx[k]];
            if (w_chain) begin
                if (w_present && !w_br_seen && !w_raw && !w_waw) begin
                    w_out_valid[k] = 1'b1;
                    w_br_seen      = r_br[w_idx[k]];
                end else begin
                    w_hazard_cut = w_present && !w_br_seen;
                    w_chain      = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_deq_n = '0;
        if (w_do_deq) begin
            for (int k = 0; k < ISSUE_W; k++) begin
                w_deq_n = w_deq_n + CW'(w_out_valid[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_enq_ok) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (in_valid[k]) begin
                    r_payload[r_tail + AW'(k)] <= in_payload[k*PAYLOAD_W +: PAYLOAD_W];
                    r_dst[r_tail + AW'(k)]     <= in_dst[k*5 +: 5];
                    r_src_a[r_tail + AW'(k)]   <= in_src_a[k*5 +: 5];
                    r_src_b[r_tail + AW'(k)]   <= in_src_b[k*5 +: 5];
                    r_wr[r_tail + AW'(k)]      <= in_wr[k];
                    r_br[r_tail + AW'(k)]      <= in_is_branch[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_multi_cnt  <= '0;
            r_hazard_cnt <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + AW'(w_enq_n);
            r_head  <= r_head + AW'(w_deq_n);
            r_count <= r_count + w_enq_n - w_deq_n;
            if (w_do_deq && w_deq_n > CW'(1))
                r_multi_cnt <= r_multi_cnt + 1'b1;
            if (w_do_deq && w_hazard_cut)
                r_hazard_cnt <= r_hazard_cnt + 1'b1;
        end
    end

endmodule
